// File: rtl/neopixel_pkg.sv
// rtl/neopixel_pkg.sv - shared constants, state encoding and helpers for the NeoPixel frame buffer
//
// Purpose: pixel word layout (GRB), frame sequencer state encoding and the
//          latch-gap cycle computation used at elaboration.
// Ports:   none (package).
package neopixel_pkg;

   localparam int PIXEL_W = 24;
   localparam int G_LSB   = 16;
   localparam int R_LSB   = 8;
   localparam int B_LSB   = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_STREAM = 2'd2,
      ST_LATCH  = 2'd3
   } np_state_e;

   // Latch gap in clock cycles; never less than one so the counter compare is well formed.
   function automatic int unsigned latch_cycles(input int unsigned clk_hz, input int unsigned us);
      int unsigned cyc;
      cyc = (clk_hz / 1000000) * us;
      return (cyc == 0) ? 1 : cyc;
   endfunction

   function automatic logic [PIXEL_W-1:0] pack_grb(input logic [7:0] g, input logic [7:0] r,
                                                    input logic [7:0] b);
      logic [PIXEL_W-1:0] w;
      w = '0;
      w[G_LSB +: 8] = g;
      w[R_LSB +: 8] = r;
      w[B_LSB +: 8] = b;
      return w;
   endfunction

endpackage

// File: rtl/neopixel_pixel_ram.sv
// rtl/neopixel_pixel_ram.sv - simple dual-port pixel RAM holding both frame banks
//
// Purpose: one write port, one synchronous read port, no reset (block RAM).
//          The bank bit is the address MSB, supplied by the caller.
// Ports:   i_clk                         clock
//          i_wr_en/i_wr_addr/i_wr_data   write port
//          i_rd_en/i_rd_addr             read request; o_rd_data updates next edge
//          o_rd_data                     read data, held while i_rd_en is low
module neopixel_pixel_ram #(
   parameter int AW    = 3,
   parameter int WIDTH = 24
) (
   input  logic             i_clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] mem_q [2**AW];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem_q[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         rd_data_q <= mem_q[i_rd_addr];
      end
   end

   assign o_rd_data = rd_data_q;

endmodule

// File: rtl/neopixel_frame_buffer.sv
// rtl/neopixel_frame_buffer.sv - double-buffered pixel store and frame sequencer for a WS2812 chain
//
// Purpose: CPU writes the back bank; the front bank is streamed one pixel at a
//          time to the serializer, followed by the latch gap. Banks swap only
//          at a frame trigger so a displayed frame never tears.
// Ports:   i_clk, i_reset (async, active high)
//          i_wr_addr/i_wr_en/i_wr_data   back-bank write port
//          i_commit                      request a swap at the next frame trigger
//          i_start                       start one frame (AUTO_REFRESH=0 only)
//          o_px_valid/o_px_data/i_px_ready  pixel stream to serializer
//          i_tx_idle                     serializer line is idle/low
//          o_busy, o_commit_pending, o_front_bank, o_frame_done  status
module neopixel_frame_buffer
   import neopixel_pkg::*;
#(
   parameter int N_PIXELS     = 64,
   parameter int ADDR_W       = 8,
   parameter int CLK_HZ       = 27000000,
   parameter int LATCH_US     = 300,
   parameter int AUTO_REFRESH = 1
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [ADDR_W-1:0]  i_wr_addr,
   input  logic               i_wr_en,
   input  logic [PIXEL_W-1:0] i_wr_data,
   input  logic               i_commit,
   input  logic               i_start,
   output logic               o_px_valid,
   output logic [PIXEL_W-1:0] o_px_data,
   input  logic               i_px_ready,
   input  logic               i_tx_idle,
   output logic               o_busy,
   output logic               o_commit_pending,
   output logic               o_front_bank,
   output logic               o_frame_done
);

   localparam int PIX_AW = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;
   localparam int unsigned LATCH_CYC = latch_cycles(CLK_HZ, LATCH_US);
   localparam int CNT_W = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
   localparam logic [PIX_AW-1:0] LAST_IDX = PIX_AW'(N_PIXELS - 1);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LATCH_CYC - 1);

   np_state_e          state_q;
   logic               front_q;
   logic               pending_q;
   logic [PIX_AW-1:0]  idx_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               valid_q;
   logic               done_q;

   logic               wr_ok_d;
   logic               trigger_d;
   logic               swap_d;
   logic [PIXEL_W-1:0] rd_data;

   assign wr_ok_d   = i_wr_en && ({{(32-ADDR_W){1'b0}}, i_wr_addr} < 32'(N_PIXELS));
   assign trigger_d = (state_q == ST_IDLE) && ((AUTO_REFRESH != 0) || i_start);
   assign swap_d    = trigger_d && pending_q;

   // Writes always target the current back bank; a write coinciding with the
   // swap edge therefore lands in the bank that becomes front.
   neopixel_pixel_ram #(
      .AW    (PIX_AW + 1),
      .WIDTH (PIXEL_W)
   ) u_ram (
      .i_clk     (i_clk),
      .i_wr_en   (wr_ok_d),
      .i_wr_addr ({~front_q, i_wr_addr[PIX_AW-1:0]}),
      .i_wr_data (i_wr_data),
      .i_rd_en   (state_q == ST_FETCH),
      .i_rd_addr ({front_q, idx_q}),
      .o_rd_data (rd_data)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         front_q   <= 1'b0;
         pending_q <= 1'b0;
         idx_q     <= '0;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;

         // A commit arriving on the swap edge is absorbed by that swap.
         if (swap_d) begin
            pending_q <= 1'b0;
         end else if (i_commit) begin
            pending_q <= 1'b1;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (trigger_d) begin
                  front_q <= front_q ^ pending_q;
                  idx_q   <= '0;
                  state_q <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               // RAM data is registered on this edge; valid rises alongside it.
               valid_q <= 1'b1;
               state_q <= ST_STREAM;
            end
            ST_STREAM: begin
               if (i_px_ready) begin
                  valid_q <= 1'b0;
                  if (idx_q == LAST_IDX) begin
                     cnt_q   <= '0;
                     state_q <= ST_LATCH;
                  end else begin
                     idx_q   <= idx_q + PIX_AW'(1);
                     state_q <= ST_FETCH;
                  end
               end
            end
            ST_LATCH: begin
               // The gap must be consecutive idle cycles; any activity restarts it.
               if (!i_tx_idle) begin
                  cnt_q <= '0;
               end else if (cnt_q == LAST_CNT) begin
                  cnt_q   <= '0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // RAM output is unreset, so the data bus is forced to zero whenever not valid.
   assign o_px_data        = valid_q ? rd_data : '0;
   assign o_px_valid       = valid_q;
   assign o_busy           = (state_q != ST_IDLE);
   assign o_commit_pending = pending_q;
   assign o_front_bank     = front_q;
   assign o_frame_done     = done_q;

endmodule

// File: doc/neopixel_frame_buffer.md
Name: neopixel_frame_buffer

Overview:
Double-buffered pixel store and frame sequencer that sits directly upstream of the NeoPixel bit serializer. The CPU writes 24-bit GRB words into the back bank. The block streams the front bank, one pixel at a time, to the serializer over a valid/ready handshake. Between frames it enforces the WS2812 latch (reset) gap, and it swaps banks only at frame boundaries so a displayed frame never tears.

Parameters:
N_PIXELS, 64, number of LEDs in the chain (1..256)
ADDR_W, 8, pixel address width; must satisfy 2**ADDR_W >= N_PIXELS
CLK_HZ, 27000000, i_clk frequency in Hz
LATCH_US, 300, minimum low time after the last bit before the next frame, in microseconds
AUTO_REFRESH, 1, 1 = restart frames continuously; 0 = start a frame only on i_start

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_wr_addr  in  ADDR_W  back-bank pixel index
i_wr_en  in  1  write strobe, one word per cycle
i_wr_data  in  24  pixel word {G[23:16], R[15:8], B[7:0]}
i_commit  in  1  pulse: request a bank swap at the next frame boundary
i_start  in  1  pulse: start one frame (ignored when AUTO_REFRESH=1)
o_px_valid  out  1  o_px_data holds a pixel for the serializer
o_px_data  out  24  pixel word, MSB shifted first
i_px_ready  in  1  serializer accepts the pixel
i_tx_idle  in  1  serializer has finished shifting its last bit; line is low
o_busy  out  1  state is not IDLE
o_commit_pending  out  1  a swap is requested but not yet applied
o_front_bank  out  1  bank currently being displayed
o_frame_done  out  1  one-cycle pulse at the end of the latch gap

Behaviour:
- Reset (asynchronous): state=IDLE, front bank=0, pending=0, pixel index=0, latch counter=0; all outputs 0. RAM contents are not reset.
- Writes go to the back bank (~front) at any time and in any state. Writes with i_wr_addr >= N_PIXELS are ignored. The front bank is never writable.
- i_commit sets pending. Repeated commits while pending have no extra effect. A commit in the same cycle as the swap is absorbed by that swap.
- A write and a commit in the same cycle: the write lands in the old back bank, which becomes the front bank at the swap.
- The swap does not copy data. After a swap, the new back bank holds the previous frame.
- LATCH_CYC = CLK_HZ/1000000*LATCH_US, computed at elaboration.
- State machine:
- IDLE: the frame trigger is AUTO_REFRESH=1, or i_start=1. On trigger: if pending, toggle front bank and clear pending (same edge); index=0; go to FETCH.
- FETCH: issue a synchronous RAM read of {front, index}. Next edge: register the data into o_px_data, set o_px_valid=1, go to STREAM.
- STREAM: hold o_px_data stable while valid && !ready. On valid && ready, clear valid. If index==N_PIXELS-1, go to LATCH; else increment index and go to FETCH.
- LATCH: the counter increments only while i_tx_idle=1 and resets to 0 whenever i_tx_idle=0. When the counter reaches LATCH_CYC-1, pulse o_frame_done, clear the counter and go to IDLE.
- Throughput is at most 1 pixel per 2 cycles. This is ample, since the serializer needs 24 × 1.25 µs per pixel.
- i_start outside IDLE is dropped, not queued. i_commit during FETCH, STREAM or LATCH is deferred to the next IDLE trigger.
- The front bank is constant from the IDLE trigger to o_frame_done.
- i_reset asserted mid-frame aborts immediately. o_px_valid drops asynchronously, and the serializer is expected to be reset by the same signal.

Decomposition:
- Package neopixel_pkg: PIXEL_W=24; GRB field offsets (G_LSB=16, R_LSB=8, B_LSB=0); a latch_cycles(clk_hz, us) function; state encoding IDLE/FETCH/STREAM/LATCH.
- Sub-module neopixel_pixel_ram: simple dual-port RAM, 2*N_PIXELS × 24, one write port and one synchronous-read port, bank bit as address MSB, no reset. It maps to BSRAM.

Test Plan:
Use overrides N_PIXELS=4, CLK_HZ=1000000, LATCH_US=5, so LATCH_CYC=5.
1. Write back bank with 0x0000FF, 0x00FF00, 0xFF0000, 0x123456; commit; AUTO_REFRESH=1 with ready held 1 -> o_front_bank=1; stream is exactly those 4 words in order; o_frame_done fires 5 cycles after i_tx_idle rises.
2. Ready stall: hold i_px_ready=0 for 10 cycles on pixel 2 -> o_px_valid stays 1, o_px_data stays 0xFF0000, index does not advance, no pixel is lost.
3. Commit mid-STREAM after rewriting the back bank to 0xAAAAAA -> the current frame completes with the old data; o_commit_pending=1 until the next IDLE trigger; the next frame is all 0xAAAAAA.
4. Latch gating: toggle i_tx_idle low at latch count 3 -> the counter restarts; o_frame_done arrives only after 5 consecutive idle cycles.
5. AUTO_REFRESH=0: no i_start -> o_busy stays 0; i_start pulse -> exactly one frame; an i_start pulse during STREAM produces no second frame.
6. i_reset asserted during STREAM -> o_px_valid=0, o_busy=0, o_front_bank=0, o_commit_pending=0 on the next sample. A write to i_wr_addr=4 (out of range) leaves all 4 pixels unchanged.
